// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first, through a single
// full-subtractor stage, with valid/ready handshakes on both the operand and the result sides.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  assign accept  = in_valid & in_ready;
  assign last    = (cnt_q == CntLast);
  assign d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_nxt  = (~a_sh_q[0] & b_sh_q[0]) | (br_q & ~(a_sh_q[0] ^ b_sh_q[0]));
  assign res_nxt = {d_bit, res_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
  end

  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;

  // Datapath next-state
  always_comb begin
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_nxt;
        br_d   = br_nxt;
        // Counter parks on its last value rather than wrapping.
        if (!last) cnt_d = cnt_q + CntW'(1);
        // Visible results change only when a new operation completes.
        if (last) begin
          diff_d = res_nxt;
          bout_d = br_nxt;
          ovf_d  = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: fixed vector table, hand-written corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] prev_d;
  logic         prev_b;
  logic         prev_o;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for diff/borrow, signed for overflow.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic mov);
    int r;
    int s;
    r   = int'(ma) - int'(mb) - int'(mbin);
    s   = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    md  = W'(r);
    mbo = (r < 0);
    mov = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
  endfunction

  // Entered and left at a negedge with the DUT in IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                        input logic [W-1:0] ed, input logic eb, input logic eo,
                        input int hold, input bit rnd_ordy);
    int cyc;
    chk("idle_in_ready", in_ready, 1);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    chk("run_busy", busy, 1);
    chk("run_in_ready", in_ready, 0);
    chk("run_keeps_prev_diff", diff, prev_d);
    chk("run_keeps_prev_bout", bout, prev_b);
    chk("run_keeps_prev_ovf", ovf, prev_o);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 2 * W) begin
      if (rnd_ordy) out_ready = 1'($urandom);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk("latency", cyc, W);
    chk("diff", diff, ed);
    chk("bout", bout, eb);
    chk("ovf", ovf, eo);
    chk("done_in_ready", in_ready, 0);
    chk("done_busy", busy, 1);
    repeat (hold) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_diff", diff, ed);
      chk("hold_bout", bout, eb);
      chk("hold_ovf", ovf, eo);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_diff_retained", diff, ed);
    chk("post_bout_retained", bout, eb);
    prev_d = ed; prev_b = eb; prev_o = eo;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_diff"}, diff, 0);
    chk({tag, "_bout"}, bout, 0);
    chk({tag, "_ovf"}, ovf, 0);
    prev_d = '0; prev_b = 1'b0; prev_o = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    logic [W-1:0] ra, rb, rd;
    logic         rbin, rbo, rov;

    tbl[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bo: 1'b0, ov: 1'b0};
    tbl[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bo: 1'b1, ov: 1'b0};
    tbl[2] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bo: 1'b1, ov: 1'b0};
    tbl[3] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bo: 1'b0, ov: 1'b1};
    tbl[4] = '{a: 8'h00, b: 8'h80, bin: 1'b0, d: 8'h80, bo: 1'b1, ov: 1'b1};
    tbl[5] = '{a: 8'h7F, b: 8'hFF, bin: 1'b1, d: 8'h7F, bo: 1'b1, ov: 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bo, tbl[i].ov, i % 3, 1'b1);
    end

    // Backpressure: five stalled DONE cycles with in_valid pressing new operands.
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 5, 1'b0);

    // Reset on the third RUN cycle, then a fresh operation.
    a = 8'h55; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_run_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_state("mid_rst");
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0, 1'b0);

    // Reset wins over an accept at the same edge.
    a = 8'h22; b = 8'h11; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk_reset_state("rst_vs_accept");

    // Reset in DONE wins over the output handshake and clears the held result.
    a = 8'h03; b = 8'h05; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (W) @(negedge clk);
    chk("pre_rst_done_valid", out_valid, 1);
    chk("pre_rst_done_diff", diff, 8'hFE);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    chk_reset_state("rst_in_done");

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      model(ra, rb, rbin, rd, rbo, rov);
      run_op(ra, rb, rbin, rd, rbo, rov, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; SHALL be legal for WIDTH >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand request; a, b and bin are valid while it is high.
REQ-005 in_ready  output  1  block can accept an operand request.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 bin  input  1  borrow-in into the LSB.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  borrow-out from the MSB.
REQ-013 ovf  output  1  signed (two's-complement) overflow of the subtraction.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 The block SHALL be an FSM with the states IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready=1 and out_valid=0.
REQ-017 An accept is in_valid & in_ready at a rising edge.
REQ-018 On an accept, the block SHALL capture a and b into operand shift registers, load the borrow register with bin, store a[WIDTH-1] and b[WIDTH-1], clear the bit counter and enter RUN.
REQ-019 In RUN, each cycle SHALL process one bit, LSB first, through one full-subtractor stage.
REQ-020 The full-subtractor stage SHALL compute: d = a0 ^ b0 ^ br, and br_next = (~a0 & b0) | (br & ~(a0 ^ b0)).
REQ-021 In RUN, the block SHALL shift d into the result register from the MSB end, shift both operand registers right by one, and increment the counter.
REQ-022 On the RUN cycle where counter == WIDTH-1, the block SHALL enter DONE at the next edge.
REQ-023 Latency: if an accept occurs at edge k, out_valid SHALL be 1 after edge k+WIDTH.
REQ-024 In DONE: out_valid=1; diff = the result register; bout = the final borrow register; ovf = (a_msb != b_msb) & (diff[WIDTH-1] != a_msb).
REQ-025 diff, bout and ovf SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 out_valid & out_ready at an edge SHALL return the block to IDLE, so in_ready=1 in the following cycle.
REQ-027 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes SHALL be ignored there (no overlap, no pipelining).
REQ-028 out_ready SHALL be ignored outside DONE.
REQ-029 diff, bout and ovf SHALL retain the last completed result after the return to IDLE, until the next DONE.
REQ-030 busy SHALL equal (state != IDLE).
REQ-031 The counter SHALL be sized ceil(log2(WIDTH)) bits minimum and SHALL NOT wrap within an operation.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE and zero the counter, borrow register, operand registers, result register and stored MSBs, from any state including mid-RUN and DONE.
REQ-033 After reset: in_ready=1, out_valid=0, busy=0, diff=0, bout=0, ovf=0.
REQ-034 rst SHALL take priority over an accept or an output handshake at the same edge; that operation is discarded.

Verification (WIDTH=8)
REQ-035 a=0x05, b=0x03, bin=0 accepted -> out_valid after 8 edges; diff=0x02, bout=0, ovf=0.
REQ-036 a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
REQ-037 a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0.
REQ-038 a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> outputs unchanged, in_ready=0, no new accept; then out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-040 Reset mid-operation: assert rst for one cycle on the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, busy=0, diff=0; a following operation a=0x10, b=0x01 -> diff=0x0F, bout=0.
